decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 Parameter NREGS, default 32, register count; legal values 16 (RV-E), 32. AW = clog2(NREGS).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  instruction/pc valid this cycle.
REQ-006 instruction  input  32  RV32I-encoded instruction.
REQ-007 pc  input  XLEN  address of instruction.
REQ-008 stall  input  1  downstream not accepting; hold output register.
REQ-009 flush  input  1  kill instruction being captured.
REQ-010 write_reg  input  AW  writeback destination index.
REQ-011 write_data  input  XLEN  writeback data.
REQ-012 write_reg_control  input  1  writeback enable (RegWrite).
REQ-013 ex_rd  input  5  destination of instruction in EX.
REQ-014 ex_mem_read  input  1  instruction in EX is a load.
REQ-015 hazard_stall  output  1  combinational load-use stall request to fetch.
REQ-016 out_valid  output  1  registered outputs hold a live instruction.
REQ-017 read_data_1, read_data_2  output  XLEN each  registered rs1/rs2 operands.
REQ-018 immed  output  XLEN  registered sign-extended immediate.
REQ-019 rs1, rs2, rd  output  5 each  registered register fields.
REQ-020 opcode  output  7; funct3  output  3; funct7_5  output  1 (instruction[30]); all registered.
REQ-021 pc_out  output  XLEN  registered pc.
REQ-022 illegal  output  1  registered: opcode outside RV32I base, or any used index >= NREGS.

Function
REQ-023 Register file: NREGS x XLEN; write on clk edge when write_reg_control and write_reg != 0; writes proceed regardless of stall/flush/in_valid.
REQ-024 x0 always reads 0.
REQ-025 Latency: one cycle; fields decoded from instruction in cycle N appear on outputs in cycle N+1.
REQ-026 Immediate by opcode: I (0010011, 0000011, 1100111, 1110011), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, placed at [31:12], sign-extended to XLEN), J (1101111, bit0=0); R-type and illegal -> 0.
REQ-027 rs1 used for all except U/J; rs2 used for R, S, B only.
REQ-028 hazard_stall = in_valid & ex_mem_read & ex_rd != 0 & (ex_rd == used rs1 | ex_rd == used rs2).
REQ-029 Capture priority per edge: flush > stall > hazard_stall > normal.
REQ-030 flush: out_valid <= 0 next cycle; other outputs don't-care.
REQ-031 stall (no flush): all outputs hold, except read_data_1/2 re-read using the held rs1/rs2 so writes during stall are seen.
REQ-032 hazard_stall (no stall/flush): bubble, out_valid <= 0.
REQ-033 Normal: out_valid <= in_valid; all fields captured.
REQ-034 illegal only meaningful when out_valid=1; illegal instruction still propagates with out_valid=1.

Reset
REQ-035 rst low: immediately clear out_valid, illegal, all registered outputs and all register file entries to 0.
REQ-036 rst asserted mid-operation discards captured instruction; first capture is on first rising edge after rst released.

Configuration
REQ-037 Macro DECODE_BYPASS_EN defined: write-to-read bypass; a write to index k in the same cycle as a read of k (k != 0) supplies write_data to the captured operand.
REQ-038 DECODE_BYPASS_EN undefined: captured operand is the pre-write register value; pipeline resolves the hazard externally.

Verification
REQ-039 Reset, then read x1..x31 -> all operands 0; write x0=0xDEADBEEF then read x0 -> 0.
REQ-040 instruction 0xFFF00093 (addi x1,x0,-1), in_valid=1 -> next cycle out_valid=1, immed=0xFFFFFFFF, rd=1, illegal=0.
REQ-041 write x5=0x12345678 same cycle as decoding add x6,x5,x5 -> read_data_1/2 = 0x12345678 with DECODE_BYPASS_EN, 0 without.
REQ-042 ex_mem_read=1, ex_rd=5, decode add x6,x5,x0 -> hazard_stall=1, next out_valid=0; same with ex_rd=0 -> hazard_stall=0.
REQ-043 stall=1 for 3 cycles with write x7=0xA5A5A5A5 while held rs1=7 -> fields unchanged, read_data_1 updates to 0xA5A5A5A5; stall+flush together -> out_valid=0.
REQ-044 NREGS=16, decode add x17,x1,x2 -> illegal=1; opcode 0x7F -> illegal=1, immed=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side instruction, writeback port, EX hazard info and registered decode results.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            in_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            flush;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  logic            write_reg_control;
  logic [4:0]      ex_rd;
  logic            ex_mem_read;

  logic            hazard_stall;
  logic            out_valid;
  logic [XLEN-1:0] read_data_1;
  logic [XLEN-1:0] read_data_2;
  logic [XLEN-1:0] immed;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport master (
    output in_valid, instruction, pc, stall, flush, write_reg, write_data,
           write_reg_control, ex_rd, ex_mem_read,
    input  hazard_stall, out_valid, read_data_1, read_data_2, immed, rs1, rs2, rd,
           opcode, funct3, funct7_5, pc_out, illegal
  );

  modport slave (
    input  in_valid, instruction, pc, stall, flush, write_reg, write_data,
           write_reg_control, ex_rd, ex_mem_read,
    output hazard_stall, out_valid, read_data_1, read_data_2, immed, rs1, rs2, rd,
           opcode, funct3, funct7_5, pc_out, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate generation, load-use detection, one-cycle output register.
// Optional DECODE_BYPASS_EN forwards a same-cycle writeback into the captured operands.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int AW    = $clog2(NREGS);
  localparam bit SMALL = (NREGS < 32);

  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_N, F_X} fmt_e;

  logic [XLEN-1:0] r_rf [NREGS];

  logic [6:0]  w_op;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  fmt_e        w_fmt;
  logic        w_rs1_used, w_rs2_used, w_rd_used, w_ill, w_hz;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm;

  logic            r_valid, r_f75, r_ill;
  logic [XLEN-1:0] r_rdata1, r_rdata2, r_imm, r_pc;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [6:0]      r_op;
  logic [2:0]      r_f3;

  assign w_op  = bus.instruction[6:0];
  assign w_rs1 = bus.instruction[19:15];
  assign w_rs2 = bus.instruction[24:20];
  assign w_rd  = bus.instruction[11:7];

  always_comb begin
    case (w_op)
      7'b0110011:                                     w_fmt = F_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = F_I;
      7'b0100011:                                     w_fmt = F_S;
      7'b1100011:                                     w_fmt = F_B;
      7'b0110111, 7'b0010111:                         w_fmt = F_U;
      7'b1101111:                                     w_fmt = F_J;
      7'b0001111:                                     w_fmt = F_N;
      default:                                        w_fmt = F_X;
    endcase
  end

  assign w_rs1_used = (w_fmt != F_U) && (w_fmt != F_J);
  assign w_rs2_used = (w_fmt == F_R) || (w_fmt == F_S) || (w_fmt == F_B);
  assign w_rd_used  = (w_fmt != F_S) && (w_fmt != F_B);

  // Indices 16..31 only exist when NREGS is 32.
  assign w_ill = (w_fmt == F_X)
               || (w_rs1_used && SMALL && w_rs1[4])
               || (w_rs2_used && SMALL && w_rs2[4])
               || (w_rd_used  && SMALL && w_rd[4]);

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      F_I: w_imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
      F_S: w_imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:25], bus.instruction[11:7]};
      F_B: w_imm32 = {{20{bus.instruction[31]}}, bus.instruction[7], bus.instruction[30:25],
                      bus.instruction[11:8], 1'b0};
      F_U: w_imm32 = {bus.instruction[31:12], 12'b0};
      F_J: w_imm32 = {{12{bus.instruction[31]}}, bus.instruction[19:12], bus.instruction[20],
                      bus.instruction[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end
  assign w_imm = XLEN'($signed(w_imm32));

  assign w_hz = bus.in_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0)
             && ((w_rs1_used && bus.ex_rd == w_rs1) || (w_rs2_used && bus.ex_rd == w_rs2));
  assign bus.hazard_stall = w_hz;

  // While stalled the read ports follow the held indices so writebacks land in the held operands.
  logic [4:0]      w_src   [2];
  logic [XLEN-1:0] w_rdata [2];
  assign w_src[0] = bus.stall ? r_rs1 : w_rs1;
  assign w_src[1] = bus.stall ? r_rs2 : w_rs2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rdata[p] = '0;
      if (w_src[p] != 5'd0 && !(SMALL && w_src[p][4])) begin
        w_rdata[p] = r_rf[w_src[p][AW-1:0]];
`ifdef DECODE_BYPASS_EN
        if (bus.write_reg_control && bus.write_reg == w_src[p][AW-1:0])
          w_rdata[p] = bus.write_data;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) r_rf[k] <= '0;
    end else if (bus.write_reg_control && bus.write_reg != '0) begin
      r_rf[bus.write_reg] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_ill    <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_op     <= '0;
      r_f3     <= '0;
      r_f75    <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (bus.stall) begin
      r_rdata1 <= w_rdata[0];
      r_rdata2 <= w_rdata[1];
    end else if (w_hz) begin
      r_valid <= 1'b0;
    end else begin
      r_valid  <= bus.in_valid;
      r_ill    <= w_ill;
      r_rdata1 <= w_rdata[0];
      r_rdata2 <= w_rdata[1];
      r_imm    <= w_imm;
      r_pc     <= bus.pc;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rd     <= w_rd;
      r_op     <= w_op;
      r_f3     <= bus.instruction[14:12];
      r_f75    <= bus.instruction[30];
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.illegal     = r_ill;
  assign bus.read_data_1 = r_rdata1;
  assign bus.read_data_2 = r_rdata2;
  assign bus.immed       = r_imm;
  assign bus.pc_out      = r_pc;
  assign bus.rs1         = r_rs1;
  assign bus.rs2         = r_rs2;
  assign bus.rd          = r_rd;
  assign bus.opcode      = r_op;
  assign bus.funct3      = r_f3;
  assign bus.funct7_5    = r_f75;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: NREGS=32 and NREGS=16 instances driven in lockstep against a behavioural model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, stall = 0, flush = 0, wen = 0, exm = 0;
  logic [31:0] instr = '0, pc = '0, wdata = '0;
  logic [4:0]  wr = '0, ex_rd = '0;

  decode_stage_if #(.XLEN(32), .NREGS(32)) b32();
  decode_stage_if #(.XLEN(32), .NREGS(16)) b16();

  assign b32.in_valid = in_valid;  assign b16.in_valid = in_valid;
  assign b32.instruction = instr;  assign b16.instruction = instr;
  assign b32.pc = pc;              assign b16.pc = pc;
  assign b32.stall = stall;        assign b16.stall = stall;
  assign b32.flush = flush;        assign b16.flush = flush;
  assign b32.write_reg = wr;       assign b16.write_reg = wr[3:0];
  assign b32.write_data = wdata;   assign b16.write_data = wdata;
  assign b32.write_reg_control = wen; assign b16.write_reg_control = wen;
  assign b32.ex_rd = ex_rd;        assign b16.ex_rd = ex_rd;
  assign b32.ex_mem_read = exm;    assign b16.ex_mem_read = exm;

  decode_stage #(.XLEN(32), .NREGS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  decode_stage #(.XLEN(32), .NREGS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } exp_t;

  exp_t        cur [2];
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] rf [2][32];
  int          n_chk = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic byte fmt_of(logic [6:0] op);
    case (op)
      7'h33:                      return "R";
      7'h13, 7'h03, 7'h67, 7'h73: return "I";
      7'h23:                      return "S";
      7'h63:                      return "B";
      7'h37, 7'h17:               return "U";
      7'h6F:                      return "J";
      7'h0F:                      return "N";
      default:                    return "X";
    endcase
  endfunction

  // Immediates assembled by arithmetic shifts of the whole word rather than bit concatenation.
  function automatic logic [31:0] imm_of(logic [31:0] ins);
    logic signed [31:0] s;
    s = $signed(ins);
    case (fmt_of(ins[6:0]))
      "I": return 32'(s >>> 20);
      "S": return (32'(s >>> 20) & 32'hFFFFFFE0) | 32'(ins[11:7]);
      "B": return (32'(s >>> 19) & 32'hFFFFF000) | (32'(ins[7]) << 11)
                | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      "U": return ins & 32'hFFFFF000;
      "J": return (32'(s >>> 11) & 32'hFFF00000) | (32'(ins[19:12]) << 12)
                | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(int k, logic [4:0] idx);
    int n = (k == 1) ? 16 : 32;
    logic [4:0] widx = (k == 1) ? {1'b0, wr[3:0]} : wr;
    if (idx == 0 || int'(idx) >= n) return 32'h0;
`ifdef DECODE_BYPASS_EN
    if (wen && widx == idx) return wdata;
`endif
    return rf[k][idx];
  endfunction

  task automatic model_edge();
    byte f;
    logic [4:0] r1, r2, rdf, widx;
    bit u1, u2, ud, hz;
    int n;
    f = fmt_of(instr[6:0]);
    r1 = instr[19:15]; r2 = instr[24:20]; rdf = instr[11:7];
    u1 = (f != "U") && (f != "J");
    u2 = (f == "R") || (f == "S") || (f == "B");
    ud = (f != "S") && (f != "B");
    hz = in_valid && exm && ex_rd != 0 && ((u1 && ex_rd == r1) || (u2 && ex_rd == r2));
    chk("hazard_stall_n32", b32.hazard_stall, hz);
    chk("hazard_stall_n16", b16.hazard_stall, hz);
    for (int k = 0; k < 2; k++) begin
      n = (k == 1) ? 16 : 32;
      if (flush) cur[k].valid = 0;
      else if (stall) begin
        cur[k].rd1 = mread(k, cur[k].rs1);
        cur[k].rd2 = mread(k, cur[k].rs2);
      end else if (hz) cur[k].valid = 0;
      else begin
        cur[k].valid = in_valid;
        cur[k].rd1 = mread(k, r1);
        cur[k].rd2 = mread(k, r2);
        cur[k].imm = imm_of(instr);
        cur[k].pc = pc;
        cur[k].rs1 = r1; cur[k].rs2 = r2; cur[k].rd = rdf;
        cur[k].op = instr[6:0]; cur[k].f3 = instr[14:12]; cur[k].f7 = instr[30];
        cur[k].ill = (f == "X") || (u1 && int'(r1) >= n) || (u2 && int'(r2) >= n)
                  || (ud && int'(rdf) >= n);
      end
    end
    for (int k = 0; k < 2; k++) begin
      widx = (k == 1) ? {1'b0, wr[3:0]} : wr;
      if (wen && widx != 0) rf[k][widx] = wdata;
    end
    q0.push_back(cur[0]);
    q1.push_back(cur[1]);
  endtask

  function automatic exp_t get_act(int k);
    exp_t a;
    if (k == 0) begin
      a.valid = b32.out_valid; a.rd1 = b32.read_data_1; a.rd2 = b32.read_data_2;
      a.imm = b32.immed; a.pc = b32.pc_out; a.rs1 = b32.rs1; a.rs2 = b32.rs2; a.rd = b32.rd;
      a.op = b32.opcode; a.f3 = b32.funct3; a.f7 = b32.funct7_5; a.ill = b32.illegal;
    end else begin
      a.valid = b16.out_valid; a.rd1 = b16.read_data_1; a.rd2 = b16.read_data_2;
      a.imm = b16.immed; a.pc = b16.pc_out; a.rs1 = b16.rs1; a.rs2 = b16.rs2; a.rd = b16.rd;
      a.op = b16.opcode; a.f3 = b16.funct3; a.f7 = b16.funct7_5; a.ill = b16.illegal;
    end
    return a;
  endfunction

  task automatic compare(string t, exp_t e, exp_t a);
    chk({t, ".out_valid"}, a.valid, e.valid);
    if (e.valid) begin
      chk({t, ".read_data_1"}, a.rd1, e.rd1);
      chk({t, ".read_data_2"}, a.rd2, e.rd2);
      chk({t, ".immed"}, a.imm, e.imm);
      chk({t, ".pc_out"}, a.pc, e.pc);
      chk({t, ".fields"}, {a.rs1, a.rs2, a.rd, a.op, a.f3, a.f7}, {e.rs1, e.rs2, e.rd, e.op, e.f3, e.f7});
      chk({t, ".illegal"}, a.ill, e.ill);
    end
  endtask

  task automatic chk_reset_zero();
    exp_t a;
    for (int k = 0; k < 2; k++) begin
      a = get_act(k);
      chk("reset_outputs", {a.valid, a.ill, a.rd1, a.rd2, a.imm, a.pc, a.rs1, a.rs2, a.rd, a.op},
          64'h0);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      cur[k] = '{default: '0};
      for (int i = 0; i < 32; i++) rf[k][i] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (q0.size() > 0) compare("n32", q0.pop_front(), get_act(0));
    if (q1.size() > 0) compare("n16", q1.pop_front(), get_act(1));
  end

  task automatic drv(bit iv, logic [31:0] ins, bit st, bit fl, bit we, logic [4:0] wreg,
                     logic [31:0] wd, logic [4:0] erd, bit em);
    in_valid = iv; instr = ins; stall = st; flush = fl; wen = we; wr = wreg; wdata = wd;
    ex_rd = erd; exm = em;
    pc = pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic drv_rand();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] ins;
    logic [4:0]  erd;
    ins = ($urandom() & 32'hFFFFFF80) | {25'd0, ops[$urandom_range(0, 10)]};
    case ($urandom_range(0, 2))
      0: erd = ins[19:15];
      1: erd = ins[24:20];
      default: erd = 5'($urandom_range(0, 31));
    endcase
    drv($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
        1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), erd,
        $urandom_range(0, 2) == 0);
  endtask

  initial begin
    clear_model();
    pc = $urandom() & 32'hFFFFFFFC;
    repeat (2) @(negedge clk);
    chk_reset_zero();
    rst = 1'b1;

    drv(0, 32'h0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 0);
    for (int n = 1; n < 32; n++)
      drv(1, (32'(n) << 20) | (32'(n) << 15) | 32'h000000B3, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h000000B3, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 0);
    drv(1, 32'h000000B3, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'hFFF00093, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h00528333, 0, 0, 1, 5'd5, 32'h12345678, 0, 0);
    drv(1, 32'h00028333, 0, 0, 0, 0, 0, 5'd5, 1);
    drv(1, 32'h00028333, 0, 0, 0, 0, 0, 5'd0, 1);
    drv(1, 32'h00038433, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h00B50533, 1, 0, 1, 5'd7, 32'hA5A5A5A5, 0, 0);
    drv(1, 32'h00B50533, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h00B50533, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h00B50533, 1, 1, 0, 0, 0, 0, 0);
    drv(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h002088B3, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'hFE208EE3, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'hFE112E23, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h800000EF, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 32'h80000137, 0, 0, 0, 0, 0, 0, 0);

    repeat (600) drv_rand();

    // Asynchronous reset in the middle of a cycle must clear outputs without waiting for an edge.
    #2 rst = 1'b0;
    #1 chk_reset_zero();
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    repeat (50) drv_rand();
    drv(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
